// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_scanner
//  Purpose  : Matrix keypad scanner with frame debounce and rollover guard.
//  Revision : 1.0
// ============================================================================
module keypad_scanner #(
   parameter int ROWS     = 4,
   parameter int COLS     = 4,
   parameter int SCAN_DIV = 50000,
   parameter int DEBOUNCE = 4,
   parameter int CODE_W   = $clog2(ROWS*COLS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ROWS-1:0]   rows,
   output logic [COLS-1:0]   cols,
   output logic [CODE_W-1:0] key_code,
   output logic              key_valid,
   output logic              key_held,
   output logic              multi_key
);

   localparam int NKEYS = ROWS*COLS;
   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int COL_W = $clog2(COLS);
   localparam int CNT_W = $clog2(DEBOUNCE+1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV-1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS-1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEBOUNCE);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      MULTI   = 2'd2
   } state_t;

   logic [DIV_W-1:0]  div_q;
   logic [COL_W-1:0]  col_q;
   logic [COLS-1:0]   cols_q;
   logic [NKEYS-1:0]  snap_q, snap_d, prev_q;
   logic [CNT_W-1:0]  stable_cnt_q;
   logic              decide_q;
   logic              w_col_done, w_frame_end, w_decide;
   logic              w_any, w_many;
   logic [CODE_W-1:0] w_code;

   state_t            state_q, state_d;
   logic [CODE_W-1:0] key_code_q, key_code_d;
   logic              key_valid_q, key_valid_d;
   logic              key_held_q, key_held_d;
   logic              multi_key_q, multi_key_d;

   assign w_col_done  = (div_q == DIV_LAST);
   assign w_frame_end = w_col_done && (col_q == COL_LAST);
   assign w_decide    = decide_q && (stable_cnt_q == CNT_FULL);

   // Snapshot bit index is row*COLS+col, so a single set bit's index is the key code.
   always_comb begin
      snap_d = snap_q;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            if (COL_W'(c) == col_q) begin
               snap_d[r*COLS+c] = rows[r];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q        <= '0;
         col_q        <= '0;
         cols_q       <= {{(COLS-1){1'b0}}, 1'b1};
         snap_q       <= '0;
         prev_q       <= '0;
         stable_cnt_q <= '0;
         decide_q     <= 1'b0;
      end else begin
         decide_q <= w_frame_end;
         if (w_col_done) begin
            div_q  <= '0;
            snap_q <= snap_d;
            cols_q <= {cols_q[COLS-2:0], cols_q[COLS-1]};
            if (col_q == COL_LAST) begin
               col_q <= '0;
            end else begin
               col_q <= col_q + COL_W'(1);
            end
         end else begin
            div_q <= div_q + DIV_W'(1);
         end
         if (w_frame_end) begin
            prev_q <= snap_d;
            if (snap_d != prev_q) begin
               stable_cnt_q <= CNT_W'(1);
            end else if (stable_cnt_q != CNT_FULL) begin
               stable_cnt_q <= stable_cnt_q + CNT_W'(1);
            end
         end
      end
   end

   // Classify the stable snapshot as zero / one / many keys.
   always_comb begin
      w_any  = 1'b0;
      w_many = 1'b0;
      w_code = '0;
      for (int i = 0; i < NKEYS; i++) begin
         if (prev_q[i]) begin
            if (w_any) begin
               w_many = 1'b1;
            end
            w_any  = 1'b1;
            w_code = CODE_W'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         key_code_q  <= '0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
         multi_key_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
         multi_key_q <= multi_key_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      key_held_d  = key_held_q;
      multi_key_d = multi_key_q;
      if (w_decide) begin
         case (state_q)
            IDLE: begin
               if (w_many) begin
                  multi_key_d = 1'b1;
                  state_d     = MULTI;
               end else if (w_any) begin
                  key_code_d  = w_code;
                  key_valid_d = 1'b1;
                  key_held_d  = 1'b1;
                  state_d     = PRESSED;
               end
            end
            // A slide to another single key is ignored until a stable release.
            PRESSED: begin
               if (w_many) begin
                  multi_key_d = 1'b1;
                  state_d     = MULTI;
               end else if (!w_any) begin
                  key_held_d = 1'b0;
                  state_d    = IDLE;
               end
            end
            MULTI: begin
               if (!w_any) begin
                  multi_key_d = 1'b0;
                  key_held_d  = 1'b0;
                  state_d     = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign cols      = cols_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign key_held  = key_held_q;
   assign multi_key = multi_key_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_scanner
//  Purpose  : Self-checking bench for keypad_scanner (4x4 and 3x5 instances).
//  Revision : 1.0
// ============================================================================
module tb_keypad_scanner;

   localparam int R    = 4;
   localparam int C    = 4;
   localparam int DIV  = 4;
   localparam int DEB  = 2;
   localparam int FR   = C*DIV;
   localparam int RG   = 3;
   localparam int CG   = 5;
   localparam int DIVG = 2;
   localparam int DEBG = 1;
   localparam int FRG  = CG*DIVG;
   localparam int NSTEP = 18;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, rst_g;
   logic [R*C-1:0] mask;
   logic [RG*CG-1:0] mask_g;
   logic [R-1:0]  rows;
   logic [C-1:0]  cols;
   logic [3:0]    key_code;
   logic          key_valid, key_held, multi_key;
   logic [RG-1:0] rows_g;
   logic [CG-1:0] cols_g;
   logic [3:0]    key_code_g;
   logic          key_valid_g, key_held_g, multi_key_g;

   // Keypad model: a closed key connects its driven column to its row line.
   always_comb begin
      rows = '0;
      for (int r = 0; r < R; r++) rows[r] = |(mask[r*C +: C] & cols);
   end
   always_comb begin
      rows_g = '0;
      for (int r = 0; r < RG; r++) rows_g[r] = |(mask_g[r*CG +: CG] & cols_g);
   end

   keypad_scanner #(.ROWS(R), .COLS(C), .SCAN_DIV(DIV), .DEBOUNCE(DEB)) dut (
      .clk(clk), .rst(rst), .rows(rows), .cols(cols), .key_code(key_code),
      .key_valid(key_valid), .key_held(key_held), .multi_key(multi_key));

   keypad_scanner #(.ROWS(RG), .COLS(CG), .SCAN_DIV(DIVG), .DEBOUNCE(DEBG)) dut_g (
      .clk(clk), .rst(rst_g), .rows(rows_g), .cols(cols_g), .key_code(key_code_g),
      .key_valid(key_valid_g), .key_held(key_held_g), .multi_key(multi_key_g));

   // Cycle index since reset release; cycle 0 is the first cycle of frame 0.
   int t, t_g;
   always @(posedge clk) begin
      if (rst) t <= 0; else t <= t + 1;
      if (rst_g) t_g <= 0; else t_g <= t_g + 1;
   end

   typedef struct { int t_exp; int code; } exp_t;
   exp_t sb[$];
   exp_t sb_g[$];
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d (t=%0d)", name, act, exp, t);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst && key_valid) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected key_valid: got pulse code %0d at t=%0d, required none", key_code, t);
         end else begin
            e = sb.pop_front();
            check("key_valid time", t, e.t_exp);
            check("key_valid code", key_code, e.code);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rst_g && key_valid_g) begin
         if (sb_g.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected key_valid_g: got pulse code %0d at t=%0d, required none", key_code_g, t_g);
         end else begin
            e = sb_g.pop_front();
            check("key_valid_g time", t_g, e.t_exp);
            check("key_valid_g code", key_code_g, e.code);
         end
      end
   end

   typedef struct {
      logic [15:0] mask;
      int          frames;
      bit          pulse;
      int          code;
      bit          held;
      bit          multi;
   } step_t;

   initial begin
      step_t steps[NSTEP];
      exp_t  e;
      int    frame;
      bit    prev_held, prev_multi;

      //            mask     frm pulse code held multi
      steps[0]  = '{16'h0000, 3, 1'b0, 0,  1'b0, 1'b0};
      steps[1]  = '{16'h0200, 3, 1'b1, 9,  1'b1, 1'b0};  // (2,1)
      steps[2]  = '{16'h0000, 3, 1'b0, 9,  1'b0, 1'b0};
      steps[3]  = '{16'h0008, 1, 1'b0, 9,  1'b0, 1'b0};  // bounce (0,3)
      steps[4]  = '{16'h0000, 1, 1'b0, 9,  1'b0, 1'b0};
      steps[5]  = '{16'h0008, 1, 1'b0, 9,  1'b0, 1'b0};
      steps[6]  = '{16'h0000, 1, 1'b0, 9,  1'b0, 1'b0};
      steps[7]  = '{16'h0008, 1, 1'b0, 9,  1'b0, 1'b0};
      steps[8]  = '{16'h0000, 1, 1'b0, 9,  1'b0, 1'b0};
      steps[9]  = '{16'h0008, 3, 1'b1, 3,  1'b1, 1'b0};
      steps[10] = '{16'h0000, 3, 1'b0, 3,  1'b0, 1'b0};
      steps[11] = '{16'h0021, 3, 1'b0, 3,  1'b0, 1'b1};  // (0,0)+(1,1)
      steps[12] = '{16'h0001, 3, 1'b0, 3,  1'b0, 1'b1};
      steps[13] = '{16'h0000, 3, 1'b0, 3,  1'b0, 1'b0};
      steps[14] = '{16'h8000, 3, 1'b1, 15, 1'b1, 1'b0};  // (3,3)
      steps[15] = '{16'h0000, 3, 1'b0, 15, 1'b0, 1'b0};
      steps[16] = '{16'h0001, 3, 1'b1, 0,  1'b1, 1'b0};  // (0,0)
      steps[17] = '{16'h0002, 3, 1'b0, 0,  1'b1, 1'b0};  // slide to (0,1)

      rst    = 1'b1;
      rst_g  = 1'b1;
      mask   = '0;
      mask_g = '0;
      repeat (3) @(negedge clk);
      check("reset cols", cols, 1);
      check("reset key_code", key_code, 0);
      check("reset key_valid", key_valid, 0);
      check("reset key_held", key_held, 0);
      check("reset multi_key", multi_key, 0);
      rst = 1'b0;

      for (int i = 0; i < 20; i++) begin
         check("cols rotation", cols, 32'(1 << ((i / DIV) % C)));
         @(negedge clk);
      end
      repeat (2*FR - 20) @(negedge clk);
      frame      = 2;
      prev_held  = 1'b0;
      prev_multi = 1'b0;

      for (int s = 0; s < NSTEP; s++) begin
         mask = steps[s].mask;
         if (steps[s].pulse) begin
            e.t_exp = FR*(frame + DEB) + 1;
            e.code  = steps[s].code;
            sb.push_back(e);
         end
         if (steps[s].frames >= 3) begin
            repeat (FR + 1) @(negedge clk);
            check("held before accept", key_held, prev_held);
            check("multi before accept", multi_key, prev_multi);
            repeat (FR*(steps[s].frames - 1) - 1) @(negedge clk);
         end else begin
            repeat (FR*steps[s].frames) @(negedge clk);
         end
         check("step key_held", key_held, steps[s].held);
         check("step multi_key", multi_key, steps[s].multi);
         check("step key_code", key_code, steps[s].code);
         prev_held  = steps[s].held;
         prev_multi = steps[s].multi;
         frame += steps[s].frames;
      end

      // Reset in the middle of a frame while (0,1) stays held.
      repeat (5) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("midreset cols", cols, 1);
      check("midreset key_code", key_code, 0);
      check("midreset key_held", key_held, 0);
      check("midreset multi_key", multi_key, 0);
      check("midreset key_valid", key_valid, 0);
      rst = 1'b0;
      e.t_exp = FR*DEB + 1;
      e.code  = 1;
      sb.push_back(e);
      repeat (3*FR) @(negedge clk);
      check("after reset key_held", key_held, 1);
      check("after reset key_code", key_code, 1);
      check("after reset multi_key", multi_key, 0);

      // 3x5 instance with single-frame debounce.
      check("g reset cols", cols_g, 1);
      check("g reset key_code", key_code_g, 0);
      rst_g = 1'b0;
      for (int i = 0; i < 20; i++) begin
         check("g cols rotation", cols_g, 32'(1 << ((i / DIVG) % CG)));
         @(negedge clk);
      end
      mask_g = 15'(1 << 14);  // (2,4)
      e.t_exp = FRG*(2 + DEBG) + 1;
      e.code  = 14;
      sb_g.push_back(e);
      repeat (3*FRG) @(negedge clk);
      check("g key_held", key_held_g, 1);
      check("g key_code", key_code_g, 14);
      check("g multi_key", multi_key_g, 0);
      mask_g = '0;
      repeat (2*FRG) @(negedge clk);
      check("g release key_held", key_held_g, 0);
      check("g release key_code", key_code_g, 14);

      repeat (4) @(negedge clk);
      check("pending pulses", sb.size(), 0);
      check("g pending pulses", sb_g.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
